// File: rtl/counter_pkg.sv
// Shared definitions for the up/down modulo counter family.
//   DIR_UP / DIR_DN     : values of the up_dn direction input
//   MODE_WRAP / MODE_SAT: values of the SATURATE parameter
//   nx_code_e           : classification of the per-edge update, for debug/coverage
package counter_pkg;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT  = 1;

  typedef enum logic [2:0] {
    NX_HOLD,
    NX_INC,
    NX_DEC,
    NX_WRAP,
    NX_LOAD,
    NX_CLR
  } nx_code_e;

endpackage

// File: rtl/syn_counter_next.sv
// Combinational next-state logic for syn_updown_mod_counter.
// Ports:
//   i_q          current count (always within 0..MODULUS-1)
//   i_en         count enable
//   i_up_dn      direction, DIR_UP / DIR_DN
//   i_load, i_d  parallel load request and value (clamped to MODULUS-1)
//   i_clr        synchronous clear
//   o_q_next     count after the next rising edge
//   o_nx_code    which kind of update is happening
//   o_wrap_next  the edge wraps around a range end
//   o_limit_next o_q_next sits at the range end for the current direction
module syn_counter_next
  import counter_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int MODULUS  = 16,
  parameter int SATURATE = MODE_WRAP
) (
  input  logic [WIDTH-1:0] i_q,
  input  logic             i_en,
  input  logic             i_up_dn,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_d,
  input  logic             i_clr,
  output logic [WIDTH-1:0] o_q_next,
  output nx_code_e         o_nx_code,
  output logic             o_wrap_next,
  output logic             o_limit_next
);

  localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  always_comb begin
    o_q_next    = i_q;
    o_nx_code   = NX_HOLD;
    o_wrap_next = 1'b0;
    if (i_clr) begin
      o_q_next  = '0;
      o_nx_code = NX_CLR;
    end else if (i_load) begin
      o_q_next  = (i_d > MAX) ? MAX : i_d;
      o_nx_code = NX_LOAD;
    end else if (i_en) begin
      if (i_up_dn == DIR_UP) begin
        if (i_q < MAX) begin
          o_q_next  = i_q + ONE;
          o_nx_code = NX_INC;
        end else if (SATURATE != MODE_SAT) begin
          o_q_next    = '0;
          o_nx_code   = NX_WRAP;
          o_wrap_next = 1'b1;
        end
      end else begin
        if (i_q != '0) begin
          o_q_next  = i_q - ONE;
          o_nx_code = NX_DEC;
        end else if (SATURATE != MODE_SAT) begin
          o_q_next    = MAX;
          o_nx_code   = NX_WRAP;
          o_wrap_next = 1'b1;
        end
      end
    end
  end

  // Limit is judged against the direction sampled on this edge, for every
  // kind of update (clear, load and hold included).
  assign o_limit_next = (i_up_dn == DIR_UP) ? (o_q_next == MAX) : (o_q_next == '0);

endmodule

// File: rtl/syn_updown_mod_counter.sv
// Synchronous up/down modulo-MODULUS counter with load, clear, enable and
// optional saturation at the range ends.
// Ports:
//   clk, reset_n  rising-edge clock, asynchronous active-low reset
//   en, up_dn     count enable, direction (1 = up)
//   load, d       synchronous parallel load (d clamped to MODULUS-1)
//   clr           synchronous clear, highest priority
//   Q             registered count
//   tc            combinational terminal count for cascading
//   wrap          one-cycle registered pulse after a wrap-around
//   at_limit      registered, Q sits at the range end for the sampled direction
module syn_updown_mod_counter
  import counter_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int MODULUS  = 16,
  parameter int SATURATE = MODE_WRAP
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic             clr,
  output logic [WIDTH-1:0] Q,
  output logic             tc,
  output logic             wrap,
  output logic             at_limit
);

  localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);

  if (MODULUS < 2 || longint'(MODULUS) > (longint'(1) << WIDTH)) begin : g_bad_modulus
    $error("syn_updown_mod_counter: MODULUS must lie in [2, 2**WIDTH]");
  end

  logic [WIDTH-1:0] r_q;
  logic             r_wrap;
  logic             r_at_limit;

  logic [WIDTH-1:0] w_q_next;
  nx_code_e         w_nx_code;
  logic             w_wrap_next;
  logic             w_limit_next;

  syn_counter_next #(
    .WIDTH   (WIDTH),
    .MODULUS (MODULUS),
    .SATURATE(SATURATE)
  ) u_next (
    .i_q         (r_q),
    .i_en        (en),
    .i_up_dn     (up_dn),
    .i_load      (load),
    .i_d         (d),
    .i_clr       (clr),
    .o_q_next    (w_q_next),
    .o_nx_code   (w_nx_code),
    .o_wrap_next (w_wrap_next),
    .o_limit_next(w_limit_next)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_q        <= '0;
      r_wrap     <= 1'b0;
      r_at_limit <= 1'b0;
    end else begin
      r_q        <= w_q_next;
      r_wrap     <= w_wrap_next;
      r_at_limit <= w_limit_next;
    end
  end

  // The update code is debug-only; keep it tied to the wrap decision.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      assert (w_wrap_next == (w_nx_code == NX_WRAP))
        else $error("syn_updown_mod_counter: wrap flag and update code disagree");
    end
  end

  // Masked by clr/load so a cascaded stage never advances on a cycle where
  // this stage is being cleared or loaded instead of counting.
  assign tc = en & ~clr & ~load &
              ((up_dn & (r_q == MAX)) | (~up_dn & (r_q == '0)));

  assign Q        = r_q;
  assign wrap     = r_wrap;
  assign at_limit = r_at_limit;

endmodule

// File: tb/tb_syn_updown_mod_counter.sv
module tb_syn_updown_mod_counter;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       en = 1'b0, up_dn = 1'b0, load = 1'b0, clr = 1'b0;
  logic [3:0] d = '0;

  // 0: MODULUS 10 wrap, 1: MODULUS 10 saturate, 2: MODULUS 16 wrap
  logic [3:0] q_a [3];
  logic       t_a [3];
  logic       w_a [3];
  logic       l_a [3];

  logic       c_en = 1'b0;
  logic [3:0] c0q, c1q;
  logic       c0tc, c1tc, c0w, c1w, c0l, c1l;

  int checks = 0;
  int errors = 0;

  int MODS [3] = '{10, 10, 16};
  bit SATS [3] = '{1'b0, 1'b1, 1'b0};
  int mq [3];
  bit mw [3];
  bit ml [3];
  bit last_tc [3];

  always #5 clk = ~clk;

  syn_updown_mod_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) dut_w (
    .clk(clk), .reset_n(reset_n), .en(en), .up_dn(up_dn), .load(load), .d(d), .clr(clr),
    .Q(q_a[0]), .tc(t_a[0]), .wrap(w_a[0]), .at_limit(l_a[0]));
  syn_updown_mod_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1)) dut_s (
    .clk(clk), .reset_n(reset_n), .en(en), .up_dn(up_dn), .load(load), .d(d), .clr(clr),
    .Q(q_a[1]), .tc(t_a[1]), .wrap(w_a[1]), .at_limit(l_a[1]));
  syn_updown_mod_counter #(.WIDTH(4), .MODULUS(16), .SATURATE(0)) dut_p (
    .clk(clk), .reset_n(reset_n), .en(en), .up_dn(up_dn), .load(load), .d(d), .clr(clr),
    .Q(q_a[2]), .tc(t_a[2]), .wrap(w_a[2]), .at_limit(l_a[2]));

  syn_updown_mod_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) cas0 (
    .clk(clk), .reset_n(reset_n), .en(c_en), .up_dn(1'b1), .load(1'b0), .d(4'd0), .clr(1'b0),
    .Q(c0q), .tc(c0tc), .wrap(c0w), .at_limit(c0l));
  syn_updown_mod_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) cas1 (
    .clk(clk), .reset_n(reset_n), .en(c0tc), .up_dn(1'b1), .load(1'b0), .d(4'd0), .clr(1'b0),
    .Q(c1q), .tc(c1tc), .wrap(c1w), .at_limit(c1l));

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic bit model_tc(int k, bit e, bit u, bit l, bit c);
    return e && !l && !c && (u ? (mq[k] == MODS[k] - 1) : (mq[k] == 0));
  endfunction

  // Reference: the count lives on the integer line; leaving 0..m-1 is a
  // boundary crossing that either wraps modulo m or is refused (saturate).
  function automatic void model_edge(int k, bit e, bit u, bit l, bit c, int dv);
    int m   = MODS[k];
    int nq  = mq[k];
    int raw;
    bit nw  = 1'b0;
    if (c) nq = 0;
    else if (l) nq = (dv < m) ? dv : m - 1;
    else if (e) begin
      raw = mq[k] + (u ? 1 : -1);
      if (raw >= 0 && raw < m) nq = raw;
      else if (!SATS[k]) begin
        nq = (raw + m) % m;
        nw = 1'b1;
      end
    end
    mq[k] = nq;
    mw[k] = nw;
    ml[k] = u ? (nq == m - 1) : (nq == 0);
  endfunction

  task automatic step(input bit e, input bit u, input bit l, input bit c, input logic [3:0] dv);
    @(negedge clk);
    en = e; up_dn = u; load = l; clr = c; d = dv;
    #1;
    for (int k = 0; k < 3; k++) begin
      last_tc[k] = t_a[k];
      chk($sformatf("tc[%0d]", k), int'(t_a[k]), int'(model_tc(k, e, u, l, c)));
    end
    @(posedge clk);
    for (int k = 0; k < 3; k++) model_edge(k, e, u, l, c, int'(dv));
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("Q[%0d]", k), int'(q_a[k]), mq[k]);
      chk($sformatf("wrap[%0d]", k), int'(w_a[k]), int'(mw[k]));
      chk($sformatf("at_limit[%0d]", k), int'(l_a[k]), int'(ml[k]));
    end
  endtask

  typedef struct {
    bit e, u, l, c;
    logic [3:0] d;
    int q;
    bit w, lim, tc;
  } vec_t;

  vec_t vt [16];

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    int w_exp [3];

    // Expectations below are for the MODULUS=10 wrapping instance.
    //          e  u  l  c  d      q  w  lim tc
    vt[0]  = '{0, 1, 1, 0, 4'd12, 9, 0, 1, 0};
    vt[1]  = '{1, 1, 0, 0, 4'd0,  0, 1, 0, 1};
    vt[2]  = '{1, 1, 0, 0, 4'd0,  1, 0, 0, 0};
    vt[3]  = '{1, 0, 0, 0, 4'd0,  0, 0, 1, 0};
    vt[4]  = '{1, 0, 0, 0, 4'd0,  9, 1, 0, 1};
    vt[5]  = '{1, 1, 1, 1, 4'd5,  0, 0, 0, 0};
    vt[6]  = '{1, 1, 1, 0, 4'd5,  5, 0, 0, 0};
    vt[7]  = '{1, 1, 0, 0, 4'd0,  6, 0, 0, 0};
    vt[8]  = '{1, 0, 0, 0, 4'd0,  5, 0, 0, 0};
    vt[9]  = '{1, 1, 0, 0, 4'd0,  6, 0, 0, 0};
    vt[10] = '{1, 0, 0, 0, 4'd0,  5, 0, 0, 0};
    vt[11] = '{0, 1, 0, 0, 4'd0,  5, 0, 0, 0};
    vt[12] = '{0, 0, 1, 0, 4'd9,  9, 0, 0, 0};
    vt[13] = '{1, 0, 0, 0, 4'd0,  8, 0, 0, 0};
    vt[14] = '{0, 0, 1, 0, 4'd15, 9, 0, 0, 0};
    vt[15] = '{0, 1, 0, 0, 4'd0,  9, 0, 1, 0};

    for (int k = 0; k < 3; k++) begin mq[k] = 0; mw[k] = 0; ml[k] = 0; end

    // Power-on reset
    #3;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("reset_Q[%0d]", k), int'(q_a[k]), 0);
      chk($sformatf("reset_wrap[%0d]", k), int'(w_a[k]), 0);
      chk($sformatf("reset_lim[%0d]", k), int'(l_a[k]), 0);
    end
    #4 reset_n = 1'b1;

    // Table-driven vectors
    for (int i = 0; i < 16; i++) begin
      step(vt[i].e, vt[i].u, vt[i].l, vt[i].c, vt[i].d);
      chk($sformatf("vec%0d_Q", i), int'(q_a[0]), vt[i].q);
      chk($sformatf("vec%0d_wrap", i), int'(w_a[0]), int'(vt[i].w));
      chk($sformatf("vec%0d_lim", i), int'(l_a[0]), int'(vt[i].lim));
      chk($sformatf("vec%0d_tc", i), int'(last_tc[0]), int'(vt[i].tc));
    end

    // Asynchronous reset in the middle of a count at Q=7
    step(0, 1, 0, 1, 4'd0);
    for (int i = 0; i < 7; i++) step(1, 1, 0, 0, 4'd0);
    chk("pre_reset_Q", int'(q_a[0]), 7);
    #1 reset_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("async_reset_Q[%0d]", k), int'(q_a[k]), 0);
      chk($sformatf("async_reset_wrap[%0d]", k), int'(w_a[k]), 0);
      chk($sformatf("async_reset_lim[%0d]", k), int'(l_a[k]), 0);
    end
    #1 reset_n = 1'b1;
    for (int k = 0; k < 3; k++) begin mq[k] = 0; mw[k] = 0; ml[k] = 0; end
    step(1, 1, 0, 0, 4'd0);
    chk("first_after_reset_Q", int'(q_a[0]), 1);

    // Up count through the MODULUS=10 wrap
    for (int i = 2; i <= 10; i++) begin
      step(1, 1, 0, 0, 4'd0);
      chk($sformatf("upwrap_Q_%0d", i), int'(q_a[0]), i % 10);
      chk($sformatf("upwrap_wrap_%0d", i), int'(w_a[0]), (i == 10) ? 1 : 0);
      chk($sformatf("upwrap_tc_%0d", i), int'(last_tc[0]), (i == 10) ? 1 : 0);
    end

    // Down from 1: wrapping 0,9,8 versus saturating 0,0,0
    w_exp = '{0, 9, 8};
    step(0, 0, 1, 0, 4'd1);
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, 0, 4'd0);
      chk($sformatf("down_wrap_Q_%0d", i), int'(q_a[0]), w_exp[i]);
      chk($sformatf("down_sat_Q_%0d", i), int'(q_a[1]), 0);
      chk($sformatf("down_sat_wrap_%0d", i), int'(w_a[1]), 0);
      chk($sformatf("down_sat_lim_%0d", i), int'(l_a[1]), 1);
    end

    // Randomised traffic against the reference model
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(3) != 0), 1'($urandom_range(1)),
           ($urandom_range(7) == 0), ($urandom_range(15) == 0),
           4'($urandom_range(15)));
    end

    // Two-stage decade cascade: 00..99 then back to 00
    en = 1'b0; load = 1'b0; clr = 1'b0;
    pulses = 0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      c_en = 1'b1;
      @(posedge clk);
      #1;
      chk($sformatf("cascade_count_%0d", i), int'(c1q) * 10 + int'(c0q), i % 100);
      if (c1w) pulses++;
    end
    chk("cascade_wrap_now", int'(c1w), 1);
    chk("cascade_wrap_pulses", pulses, 1);
    @(negedge clk);
    c_en = 1'b0;
    @(posedge clk);
    #1;
    chk("cascade_wrap_cleared", int'(c1w), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
